// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words from instruction memory
// over a req/ack handshake, holds each word in the instruction register for
// decode (valid/ready), and computes the next PC from the jump/branch controls.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | one settling cycle after reset release
//   REQ    | imem_req high, waiting for imem_ack at address pc
//   HOLD   | instr valid, waiting for decode to take it (instr_ready)
//   HALT   | HALT consumed; fetch stopped until the next reset
module instr_fetch_unit #(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [PC_WIDTH-1:0] imem_rdata,
   output logic [PC_WIDTH-1:0] instr,
   output logic [5:0]          opcode,
   output logic                instr_valid,
   input  logic                instr_ready,
   input  logic                branch,
   input  logic                zero,
   input  logic                jump,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] pc_plus4,
   output logic                halted
);

   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [PC_WIDTH-1:0] pc_nxt;
   logic [PC_WIDTH-1:0] instr_nxt;
   logic [PC_WIDTH-1:0] branch_off;
   logic [PC_WIDTH-1:0] branch_target;
   logic [PC_WIDTH-1:0] jump_target;
   logic [PC_WIDTH-1:0] pc_target;

   assign pc_plus4    = pc + PC_WIDTH'(4);
   assign opcode      = instr[31:26];
   assign imem_addr   = pc;
   assign imem_req    = (state == S_REQ);
   assign instr_valid = (state == S_HOLD);
   assign halted      = (state == S_HALT);

   // Word offset is sign-extended and scaled to bytes; all sums wrap naturally.
   assign branch_off    = {{(PC_WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
   assign branch_target = pc_plus4 + branch_off;
   assign jump_target   = {pc_plus4[PC_WIDTH-1:28], instr[25:0], 2'b00};

   // Next-PC select: jump beats a taken branch, which beats sequential.
   always_comb begin
      pc_target = pc_plus4;
      if (jump) begin
         pc_target = jump_target;
      end else if (branch && zero) begin
         pc_target = branch_target;
      end
   end

   // Next-state and datapath-next logic; controls only matter in HOLD with ready.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      instr_nxt = instr;
      case (state)
         S_IDLE: begin
            state_nxt = S_REQ;
         end
         S_REQ: begin
            if (imem_ack) begin
               instr_nxt = imem_rdata;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (instr_ready) begin
               pc_nxt    = pc_target;
               state_nxt = (opcode == OP_HALT) ? S_HALT : S_REQ;
            end
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register; reset drops any in-flight fetch immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // PC and instruction register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= RESET_PC;
         instr <= '0;
      end else begin
         pc    <= pc_nxt;
         instr <= instr_nxt;
      end
   end

endmodule
